// File: rtl/dispatch_router_if.sv
// Handshake bundle between rename, dispatch_router and the per-FU issue queues.
// The slave modport is the router's view; the master modport is the surrounding pipeline's view.
interface dispatch_router_if #(
  parameter int FU_COUNT     = 4,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6,
  parameter int INST_ID_BITS = 6
);
  localparam int FU_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  logic                                          in_valid;
  logic                                          in_ready;
  logic [INST_ID_BITS-1:0]                       in_inst_id;
  logic [31:0]                                   in_raw_instr;
  logic [63:0]                                   in_instr_pc;
  logic [FU_W-1:0]                               in_fu_choice;
  logic [MAX_OPERANDS-1:0]                       in_prn_in_valid;
  logic [MAX_OPERANDS-1:0]                       in_prn_in_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]         in_prn_in_prn;
  logic [MAX_OPERANDS-1:0]                       in_prn_out_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]         in_prn_out_prn;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]         wake_valid;
  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wake_prn;
  logic                                          flush;
  logic [FU_COUNT-1:0]                           dq_valid;
  logic [INST_ID_BITS-1:0]                       dq_inst_id;
  logic [31:0]                                   dq_raw_instr;
  logic [63:0]                                   dq_instr_pc;
  logic [FU_W-1:0]                               dq_fu_choice;
  logic [MAX_OPERANDS-1:0]                       dq_prn_in_valid;
  logic [MAX_OPERANDS-1:0]                       dq_prn_in_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]         dq_prn_in_prn;
  logic [MAX_OPERANDS-1:0]                       dq_prn_out_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]         dq_prn_out_prn;
  logic [FU_COUNT-1:0]                           credit_return;

  modport slave (
    input  in_valid, in_inst_id, in_raw_instr, in_instr_pc, in_fu_choice,
           in_prn_in_valid, in_prn_in_ready, in_prn_in_prn, in_prn_out_valid, in_prn_out_prn,
           wake_valid, wake_prn, flush, credit_return,
    output in_ready, dq_valid, dq_inst_id, dq_raw_instr, dq_instr_pc, dq_fu_choice,
           dq_prn_in_valid, dq_prn_in_ready, dq_prn_in_prn, dq_prn_out_valid, dq_prn_out_prn
  );

  modport master (
    output in_valid, in_inst_id, in_raw_instr, in_instr_pc, in_fu_choice,
           in_prn_in_valid, in_prn_in_ready, in_prn_in_prn, in_prn_out_valid, in_prn_out_prn,
           wake_valid, wake_prn, flush, credit_return,
    input  in_ready, dq_valid, dq_inst_id, dq_raw_instr, dq_instr_pc, dq_fu_choice,
           dq_prn_in_valid, dq_prn_in_ready, dq_prn_in_prn, dq_prn_out_valid, dq_prn_out_prn
  );
endinterface

// File: rtl/dispatch_router.sv
// In-order dispatch buffer steering renamed instructions to credit-tracked per-FU issue queues.
// Define DISPATCH_ROUTER_PERF_EN to add saturating per-FU credit-stall counters (perf_credit_stall).
module dispatch_router #(
  parameter int FU_COUNT     = 4,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6,
  parameter int INST_ID_BITS = 6,
  parameter int IQ_DEPTH     = 4,
  parameter int BUF_DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  dispatch_router_if.slave  bus
`ifdef DISPATCH_ROUTER_PERF_EN
  ,
  output logic [FU_COUNT-1:0][31:0] perf_credit_stall
`endif
);
  localparam int FU_W  = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int CR_W  = $clog2(IQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CR_W-1:0]  CR_FULL  = CR_W'(IQ_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               wv_t;
  typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wp_t;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]               inst_id;
    logic [31:0]                           raw_instr;
    logic [63:0]                           instr_pc;
    logic [FU_W-1:0]                       fu;
    logic [MAX_OPERANDS-1:0]               src_valid;
    logic [MAX_OPERANDS-1:0]               src_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src_prn;
    logic [MAX_OPERANDS-1:0]               dst_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst_prn;
  } entry_t;

  // Ready bits after folding in any same-cycle wakeup broadcast on a valid operand.
  function automatic logic [MAX_OPERANDS-1:0] wake_ops(
    input logic [MAX_OPERANDS-1:0]               vld,
    input logic [MAX_OPERANDS-1:0]               rdy,
    input logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn,
    input wv_t                                   wv,
    input wp_t                                   wp
  );
    logic [MAX_OPERANDS-1:0] r;
    r = rdy;
    for (int k = 0; k < MAX_OPERANDS; k++)
      for (int f = 0; f < FU_COUNT; f++)
        for (int s = 0; s < MAX_OPERANDS; s++)
          if (vld[k] && wv[f][s] && (wp[f][s] == prn[k])) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  entry_t                        buf_q [BUF_DEPTH];
  entry_t                        buf_d [BUF_DEPTH];
  logic [PTR_W-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [FU_COUNT-1:0][CR_W-1:0] credit_q, credit_d;
  entry_t                        head_e, in_e;
  logic                          dispatch, enq;

  always_comb begin
    head_e   = buf_q[head_q];
    dispatch = rst && !bus.flush && (count_q != '0) && (credit_q[head_e.fu] != '0);

    bus.dq_valid = '0;
    if (dispatch) bus.dq_valid[head_e.fu] = 1'b1;
    bus.in_ready = rst && !bus.flush && ((count_q < CNT_FULL) || dispatch);
    enq          = bus.in_valid && bus.in_ready;

    bus.dq_inst_id       = head_e.inst_id;
    bus.dq_raw_instr     = head_e.raw_instr;
    bus.dq_instr_pc      = head_e.instr_pc;
    bus.dq_fu_choice     = head_e.fu;
    bus.dq_prn_in_valid  = head_e.src_valid;
    bus.dq_prn_in_ready  = wake_ops(head_e.src_valid, head_e.src_ready, head_e.src_prn,
                                    bus.wake_valid, bus.wake_prn);
    bus.dq_prn_in_prn    = head_e.src_prn;
    bus.dq_prn_out_valid = head_e.dst_valid;
    bus.dq_prn_out_prn   = head_e.dst_prn;

    in_e.inst_id   = bus.in_inst_id;
    in_e.raw_instr = bus.in_raw_instr;
    in_e.instr_pc  = bus.in_instr_pc;
    in_e.fu        = bus.in_fu_choice;
    in_e.src_valid = bus.in_prn_in_valid;
    in_e.src_ready = wake_ops(bus.in_prn_in_valid, bus.in_prn_in_ready, bus.in_prn_in_prn,
                              bus.wake_valid, bus.wake_prn);
    in_e.src_prn   = bus.in_prn_in_prn;
    in_e.dst_valid = bus.in_prn_out_valid;
    in_e.dst_prn   = bus.in_prn_out_prn;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      buf_d[i]           = buf_q[i];
      buf_d[i].src_ready = wake_ops(buf_q[i].src_valid, buf_q[i].src_ready, buf_q[i].src_prn,
                                    bus.wake_valid, bus.wake_prn);
    end
    if (enq) begin
      buf_d[tail_q] = in_e;
      tail_d        = ptr_inc(tail_q);
    end
    if (dispatch) head_d = ptr_inc(head_q);
    unique case ({enq, dispatch})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flushed entries keep their credits; the issue queues hand them back later.
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    credit_d = credit_q;
    for (int f = 0; f < FU_COUNT; f++) begin
      if (dispatch && (head_e.fu == FU_W'(f)) && !bus.credit_return[f])
        credit_d[f] = credit_q[f] - 1'b1;
      else if (!(dispatch && (head_e.fu == FU_W'(f))) && bus.credit_return[f] &&
               (credit_q[f] != CR_FULL))
        credit_d[f] = credit_q[f] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      credit_q <= {FU_COUNT{CR_FULL}};
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

`ifdef DISPATCH_ROUTER_PERF_EN
  logic [FU_COUNT-1:0][31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int f = 0; f < FU_COUNT; f++)
      if (rst && !bus.flush && (count_q != '0) && (head_e.fu == FU_W'(f)) &&
          (credit_q[f] == '0) && (perf_q[f] != '1))
        perf_d[f] = perf_q[f] + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_credit_stall = perf_q;
`endif
endmodule

// File: tb/tb_dispatch_router.sv
// Self-checking bench for dispatch_router: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the dispatch buffer and credits.
module tb_dispatch_router;
  localparam int FU = 4, MO = 3, PB = 6, IB = 6, IQD = 4, BD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dispatch_router_if #(.FU_COUNT(FU), .MAX_OPERANDS(MO), .PRN_BITS(PB), .INST_ID_BITS(IB)) bus ();
`ifdef DISPATCH_ROUTER_PERF_EN
  logic [FU-1:0][31:0] perf;
`endif

  dispatch_router #(.FU_COUNT(FU), .MAX_OPERANDS(MO), .PRN_BITS(PB), .INST_ID_BITS(IB),
                    .IQ_DEPTH(IQD), .BUF_DEPTH(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DISPATCH_ROUTER_PERF_EN
    ,
    .perf_credit_stall (perf)
`endif
  );

  typedef struct {
    logic [IB-1:0]          id;
    logic [63:0]            pc;
    int                     fu;
    logic [MO-1:0]          iv;
    logic [MO-1:0]          ir;
    logic [MO-1:0][PB-1:0]  ip;
  } ent_t;

  ent_t          mq[$];
  int            cr[FU];
  int            stall[FU];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            exp_disp, exp_rdy;
  logic [FU-1:0] exp_dqv;
  logic [MO-1:0] exp_ir;

  function automatic bit woke(input logic [PB-1:0] p);
    for (int f = 0; f < FU; f++)
      for (int s = 0; s < MO; s++)
        if (bus.wake_valid[f][s] && bus.wake_prn[f][s] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_eval();
    exp_disp = 1'b0;
    exp_dqv  = '0;
    exp_ir   = '0;
    if (mq.size() > 0) begin
      exp_disp = rst && !bus.flush && cr[mq[0].fu] > 0;
      for (int k = 0; k < MO; k++)
        exp_ir[k] = mq[0].ir[k] | (mq[0].iv[k] & woke(mq[0].ip[k]));
      if (exp_disp) exp_dqv[mq[0].fu] = 1'b1;
    end
    exp_rdy = rst && !bus.flush && (mq.size() < BD || exp_disp);
  endfunction

  task automatic tick();
    ent_t e;
    bit   enq;
    model_eval();
    enq = bus.in_valid && exp_rdy;
    if (!rst) begin
      mq.delete();
      for (int f = 0; f < FU; f++) begin cr[f] = IQD; stall[f] = 0; end
    end else begin
      if (!bus.flush && mq.size() > 0 && cr[mq[0].fu] == 0) stall[mq[0].fu]++;
      if (exp_disp) begin cr[mq[0].fu]--; void'(mq.pop_front()); end
      for (int f = 0; f < FU; f++) if (bus.credit_return[f] && cr[f] < IQD) cr[f]++;
      foreach (mq[i])
        for (int k = 0; k < MO; k++)
          if (mq[i].iv[k] && woke(mq[i].ip[k])) mq[i].ir[k] = 1'b1;
      if (enq) begin
        e.id = bus.in_inst_id; e.pc = bus.in_instr_pc; e.fu = int'(bus.in_fu_choice);
        e.iv = bus.in_prn_in_valid; e.ip = bus.in_prn_in_prn;
        e.ir = bus.in_prn_in_ready;
        for (int k = 0; k < MO; k++) if (e.iv[k] && woke(e.ip[k])) e.ir[k] = 1'b1;
        mq.push_back(e);
      end
      if (bus.flush) mq.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.credit_return = '0;
    bus.wake_valid = '0; bus.wake_prn = '0;
  endtask

  task automatic put_inst(input int fu);
    bus.in_valid     = 1'b1;
    bus.in_fu_choice = 2'(fu);
    bus.in_inst_id   = 6'($urandom);
    bus.in_raw_instr = $urandom;
    bus.in_instr_pc  = {$urandom, $urandom};
    for (int k = 0; k < MO; k++) begin
      bus.in_prn_in_valid[k]  = 1'($urandom_range(0, 1));
      bus.in_prn_in_ready[k]  = 1'($urandom_range(0, 1));
      bus.in_prn_in_prn[k]    = 6'($urandom_range(0, 15));
      bus.in_prn_out_valid[k] = 1'($urandom_range(0, 1));
      bus.in_prn_out_prn[k]   = 6'($urandom);
    end
  endtask

  // Return credits with no new traffic until the model is empty with full credits.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      done = (mq.size() == 0);
      for (int f = 0; f < FU; f++) if (cr[f] != IQD) done = 1'b0;
      if (!done) begin
        set_idle();
        for (int f = 0; f < FU; f++) bus.credit_return[f] = (cr[f] < IQD);
        #1;
        tick();
      end
    end
    set_idle();
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL drain: model not idle, got size %0d want 0", mq.size()); end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b0;
    @(negedge clk);
    put_inst(0);
    #1;
    n_checks++; if (bus.dq_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_dqv got %b want 0000", bus.dq_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    tick();
    tick();
    rst = 1'b1;
    set_idle();
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_rdy got %b want 1", bus.in_ready); end
    n_checks++; if (bus.dq_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_release_dqv got %b want 0000", bus.dq_valid); end
    tick();
  endtask

  task automatic test_fu_sequence();
    logic [3:0] ev [5] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
    drain();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      if (c < 4) put_inst(c);
      #1;
      n_checks++; if (bus.dq_valid !== ev[c]) begin n_fail++; $display("FAIL seq_dqv c%0d got %b want %b", c, bus.dq_valid, ev[c]); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL seq_rdy c%0d got %b want 1", c, bus.in_ready); end
      tick();
    end
  endtask

  task automatic test_credit_block();
    logic [3:0] ev [9] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h1};
    bit         er [9] = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
    drain();
    for (int c = 0; c < 9; c++) begin
      set_idle();
      if (c < 5) put_inst(2); else if (c == 5) put_inst(0);
      if (c == 6) bus.credit_return[2] = 1'b1;
      #1;
      n_checks++; if (bus.dq_valid !== ev[c]) begin n_fail++; $display("FAIL credit_dqv c%0d got %b want %b", c, bus.dq_valid, ev[c]); end
      n_checks++; if (bus.in_ready !== er[c]) begin n_fail++; $display("FAIL credit_rdy c%0d got %b want %b", c, bus.in_ready, er[c]); end
      tick();
    end
  endtask

  task automatic test_hol();
    logic [3:0] ev [12] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h8};
    bit         er [12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    drain();
    for (int c = 0; c < 12; c++) begin
      set_idle();
      if (c < 5) put_inst(1); else if (c == 5) put_inst(3);
      if (c == 9) bus.credit_return[1] = 1'b1;
      #1;
      n_checks++; if (bus.dq_valid !== ev[c]) begin n_fail++; $display("FAIL hol_dqv c%0d got %b want %b", c, bus.dq_valid, ev[c]); end
      n_checks++; if (bus.in_ready !== er[c]) begin n_fail++; $display("FAIL hol_rdy c%0d got %b want %b", c, bus.in_ready, er[c]); end
      tick();
    end
  endtask

  task automatic test_wakeup();
    drain();
    set_idle();
    put_inst(0);
    bus.in_prn_in_valid = 3'b011; bus.in_prn_in_ready = 3'b000;
    bus.in_prn_in_prn[0] = 6'd18; bus.in_prn_in_prn[1] = 6'd17;
    #1; tick();
    set_idle();
    bus.wake_valid[0][1] = 1'b1; bus.wake_prn[0][1] = 6'd17;
    #1;
    n_checks++; if (bus.dq_valid !== 4'b0001) begin n_fail++; $display("FAIL wake_dqv got %b want 0001", bus.dq_valid); end
    n_checks++; if (bus.dq_prn_in_ready !== 3'b010) begin n_fail++; $display("FAIL wake_dispatch_rdy got %b want 010", bus.dq_prn_in_ready); end
    n_checks++; if (bus.dq_prn_in_prn[1] !== 6'd17) begin n_fail++; $display("FAIL wake_prn got %0d want 17", bus.dq_prn_in_prn[1]); end
    tick();
    set_idle();
    put_inst(0);
    bus.in_prn_in_valid = 3'b001; bus.in_prn_in_ready = 3'b000; bus.in_prn_in_prn[0] = 6'd21;
    bus.wake_valid[2][0] = 1'b1; bus.wake_prn[2][0] = 6'd21;
    #1; tick();
    set_idle();
    #1;
    n_checks++; if (bus.dq_prn_in_ready !== 3'b001) begin n_fail++; $display("FAIL wake_enqueue_rdy got %b want 001", bus.dq_prn_in_ready); end
    tick();
    set_idle();
    put_inst(0);
    bus.in_prn_in_valid = 3'b001; bus.in_prn_in_ready = 3'b000; bus.in_prn_in_prn[0] = 6'd20;
    #1; tick();
    set_idle();
    bus.wake_valid[3][0] = 1'b1; bus.wake_prn[3][0] = 6'd19;
    bus.wake_valid[1][2] = 1'b0; bus.wake_prn[1][2] = 6'd20;
    #1;
    n_checks++; if (bus.dq_prn_in_ready !== 3'b000) begin n_fail++; $display("FAIL wake_nomatch_rdy got %b want 000", bus.dq_prn_in_ready); end
    tick();
  endtask

  task automatic test_flush();
    logic [3:0] ev [11] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
    bit         er [11] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    drain();
    for (int c = 0; c < 11; c++) begin
      set_idle();
      if (c < 6 || c == 8 || c == 9) put_inst(3);
      if (c == 6) begin bus.flush = 1'b1; put_inst(0); end
      if (c == 7) bus.credit_return[3] = 1'b1;
      #1;
      n_checks++; if (bus.dq_valid !== ev[c]) begin n_fail++; $display("FAIL flush_dqv c%0d got %b want %b", c, bus.dq_valid, ev[c]); end
      n_checks++; if (bus.in_ready !== er[c]) begin n_fail++; $display("FAIL flush_rdy c%0d got %b want %b", c, bus.in_ready, er[c]); end
      tick();
    end
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 400; c++) begin
      set_idle();
      if ($urandom_range(0, 2) != 0) put_inst(int'($urandom_range(0, FU - 1)));
      for (int f = 0; f < FU; f++) begin
        bus.credit_return[f] = ($urandom_range(0, 2) == 0);
        for (int s = 0; s < MO; s++) begin
          bus.wake_valid[f][s] = ($urandom_range(0, 5) == 0);
          bus.wake_prn[f][s]   = 6'($urandom_range(0, 15));
        end
      end
      bus.flush = ($urandom_range(0, 39) == 0);
      #1;
      model_eval();
      n_checks++; if (bus.dq_valid !== exp_dqv) begin n_fail++; $display("FAIL rand_dqv c%0d got %b want %b", c, bus.dq_valid, exp_dqv); end
      n_checks++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_rdy c%0d got %b want %b", c, bus.in_ready, exp_rdy); end
      if (exp_disp) begin
        n_checks++; if (bus.dq_inst_id !== mq[0].id) begin n_fail++; $display("FAIL rand_id c%0d got %0d want %0d", c, bus.dq_inst_id, mq[0].id); end
        n_checks++; if (bus.dq_instr_pc !== mq[0].pc) begin n_fail++; $display("FAIL rand_pc c%0d got %h want %h", c, bus.dq_instr_pc, mq[0].pc); end
        n_checks++; if (bus.dq_prn_in_ready !== exp_ir) begin n_fail++; $display("FAIL rand_src_rdy c%0d got %b want %b", c, bus.dq_prn_in_ready, exp_ir); end
      end
      tick();
    end
  endtask

`ifdef DISPATCH_ROUTER_PERF_EN
  task automatic test_perf();
    logic [31:0] base;
    drain();
    for (int f = 0; f < FU; f++) begin
      n_checks++; if (perf[f] !== 32'(stall[f])) begin n_fail++; $display("FAIL perf_model[%0d] got %0d want %0d", f, perf[f], stall[f]); end
    end
    base = perf[0];
    for (int c = 0; c < 12; c++) begin
      set_idle();
      if (c < 5) put_inst(0);
      if (c == 11) bus.credit_return[0] = 1'b1;
      #1; tick();
    end
    set_idle();
    #1;
    n_checks++; if (perf[0] - base !== 32'd7) begin n_fail++; $display("FAIL perf_stall0 got %0d want 7", perf[0] - base); end
    rst = 1'b0;
    #1;
    n_checks++; if (perf !== '0) begin n_fail++; $display("FAIL perf_reset got %h want 0", perf); end
    tick();
    rst = 1'b1;
    #1; tick();
  endtask
`endif

  task automatic test_reset_mid();
    drain();
    for (int c = 0; c < 6; c++) begin set_idle(); put_inst(2); #1; tick(); end
    set_idle();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.dq_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_dqv got %b want 0000", bus.dq_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy got %b want 0", bus.in_ready); end
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.dq_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_empty got %b want 0000", bus.dq_valid); end
    tick();
    for (int c = 0; c < 6; c++) begin
      set_idle();
      if (c < 5) put_inst(2);
      #1;
      if (c >= 1) begin
        n_checks++;
        if (bus.dq_valid !== ((c <= 4) ? 4'h4 : 4'h0)) begin
          n_fail++; $display("FAIL midrst_credit c%0d got %b want %b", c, bus.dq_valid, (c <= 4) ? 4'h4 : 4'h0);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fu_sequence();
    test_credit_block();
    test_hol();
    test_wakeup();
    test_flush();
    test_random();
`ifdef DISPATCH_ROUTER_PERF_EN
    test_perf();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got time %0t want < 200000", $time);
    $fatal(1, "timeout");
  end
endmodule
